fsub_sched: RTL and testbench
=============================

# fsub_sched

Two-port scheduler that shares one combinational `fsub` unit (y = x1 − x2, IEEE-754 single precision, with `ovf` flag) between two requesters. It arbitrates round-robin, registers operands into the shared unit, and captures results into per-port response buffers with valid/ready handshakes. It sits between the core's FP issue logic and the single `fsub` instance. It also supports add operations by sign-flipping `x2`.

## Interface
Parameters:
- `TAGW`, default 4: width of the request/response tag.

Ports (index p ∈ {0,1}; per-port signals are 2-element packed or `_0`/`_1` pairs):
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rstn`  in  1  synchronous, active-low reset.
- `req_valid[p]`  in  1  request present.
- `req_ready[p]`  out  1  request accepted this cycle when high with `req_valid[p]`.
- `req_op[p]`  in  1  0 = sub (x1−x2), 1 = add (x1+x2).
- `req_x1[p]`, `req_x2[p]`  in  32  operands.
- `req_tag[p]`  in  TAGW  opaque tag, returned with the result.
- `resp_valid[p]`  out  1  result buffer p holds a result.
- `resp_ready[p]`  in  1  consumer takes the result.
- `resp_y[p]`  out  32  result.
- `resp_ovf[p]`  out  1  overflow flag from `fsub`.
- `resp_tag[p]`  out  TAGW  tag of the result.
- `fu_x1`, `fu_x2`  out  32  registered operands to the shared `fsub`.
- `fu_y`  in  32  `fsub` result (combinational from `fu_x1`/`fu_x2`).
- `fu_ovf`  in  1  `fsub` overflow.
- `ovf_cnt`  out  16  saturating count of completed ops with `ovf`=1.

## Operation
- Issue stage S1 holds: `s1_v`, `fu_x1`, `fu_x2`, `s1_port`, `s1_tag`. Response buffer RB[p] holds: `rb_v[p]`, y, ovf, tag. Each RB has one entry.
- `adv` = `s1_v` & (!`rb_v[s1_port]` | `resp_ready[s1_port]`). When `adv` is high, S1 contents move into RB[`s1_port`]: y←`fu_y`, ovf←`fu_ovf`, tag←`s1_tag`.
- `free` = !`s1_v` | `adv`.
- Arbitration:
  - Round-robin pointer `rr` (1 bit) names the priority port.
  - `grant[rr]` = `req_valid[rr]`; `grant[~rr]` = `req_valid[~rr]` & !`req_valid[rr]`.
  - `req_ready[p]` = `free` & `grant[p]`.
  - `req_ready` depends combinationally on `req_valid`; at most one `req_ready` is high per cycle.
- On accept of port g:
  - `fu_x1`←`req_x1[g]`.
  - `fu_x2`←`req_x2[g]` with bit 31 inverted when `req_op[g]`=1. The inversion is unconditional, so an add with a NaN x2 returns a NaN with flipped sign; this is accepted behaviour.
  - `s1_port`←g, `s1_tag`←`req_tag[g]`, `s1_v`←1, `rr`←~g.
- If there is no accept and `adv` is high, `s1_v`←0. `fu_x1`/`fu_x2` hold their last values; they are not zeroed.
- `rb_v[p]` clears on `resp_ready[p]` unless refilled the same cycle. Simultaneous drain and refill of RB[p] is allowed and keeps `rb_v[p]`=1 with the new data.
- Head-of-line blocking: if S1 is stalled on a full RB[s1_port], neither port can issue. This is intended.
- Ordering: results per port return in accept order. There is no cross-port ordering guarantee.
- `ovf_cnt` increments on each `adv` with `fu_ovf`=1 and saturates at 0xFFFF.
- `resp_*[p]` values are valid only while `resp_valid[p]`=1. RB data is held stable until drained.

## Timing
- Reset (`rstn`=0 at a rising edge) forces: `s1_v`=0, `rb_v`=0, `rr`=0, `fu_x1`=`fu_x2`=0, `s1_tag`=0, `s1_port`=0, all `resp_y`/`resp_ovf`/`resp_tag`=0, `ovf_cnt`=0.
- Reset outputs: `resp_valid`=0. `req_ready`=0 for one cycle after the reset edge only if `req_valid`=0; otherwise it follows the rules above.
- Reset mid-operation discards S1 and RB contents; no response is produced for in-flight requests.
- Latency: accept at edge N ⇒ `fu_x*` valid during cycle N+1 ⇒ `resp_valid` high in cycle N+2 (if RB was free or draining at edge N+1).
- Throughput: one op per cycle when consumers hold `resp_ready`=1.
- The combinational `fsub` path (`fu_x*` → `fu_y`) must fit one clock period. No multicycle path is assumed.

## Test plan
- Port 0 sub: 0x40400000 − 0x3F800000 accepted at edge N → `resp_valid[0]`=1 at cycle N+2, `resp_y[0]`=0x40000000, `resp_ovf[0]`=0, tag echoed.
- Port 1 add: 0x3F800000 + 0x40000000 → 0x40400000.
- Port 1 add: 0x3F800000 + 0xBF800000 → 0x00000000.
- Both ports valid each cycle with `rr`=0:
  - Grants alternate 0,1,0,1.
  - Each port sees results in order, one every 2 cycles.
  - `req_ready` is never high on both ports at once.
- Backpressure with `resp_ready[0]`=0, three port-0 ops issued:
  - First op fills RB0; second is held in S1.
  - Third op sees `req_ready[0]`=0, and a port-1 request sees `req_ready[1]`=0.
  - Raising `resp_ready[0]` drains results in order with no loss or duplication.
- Overflow: add 0x7F7FFFFF + 0x7F7FFFFF → `resp_ovf`=1 and `ovf_cnt` 0→1.
- Saturation: preloading via 65536 overflow ops holds `ovf_cnt` at 0xFFFF.
- Reset mid-flight: assert `rstn`=0 with S1 and RB0 full → next cycle all `resp_valid`=0, `ovf_cnt`=0, `rr`=0, and no stale response appears after release.

Source files
------------

// File: rtl/fsub_sched.sv
// fsub_sched: round-robin scheduler sharing one combinational fsub unit
// between two requesters. Accepted operands are registered into the shared
// unit (issue stage S1); the unit's result is captured one cycle later into a
// single-entry response buffer for the issuing port. Add is performed as a
// subtract with the sign bit of x2 inverted.
//
// Ports:
//   clk, rstn                  clock, synchronous active-low reset
//   req_valid/ready/op/x1/x2/tag  per-port request channel (index 0/1)
//   resp_valid/ready/y/ovf/tag    per-port response channel (index 0/1)
//   fu_x1, fu_x2               registered operands to the shared fsub
//   fu_y, fu_ovf               combinational fsub result
//   ovf_cnt                    saturating count of completed overflowing ops
module fsub_sched #(
    parameter int unsigned TAGW = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [1:0]           req_op,
    input  logic [1:0][31:0]     req_x1,
    input  logic [1:0][31:0]     req_x2,
    input  logic [1:0][TAGW-1:0] req_tag,
    output logic [1:0]           resp_valid,
    input  logic [1:0]           resp_ready,
    output logic [1:0][31:0]     resp_y,
    output logic [1:0]           resp_ovf,
    output logic [1:0][TAGW-1:0] resp_tag,
    output logic [31:0]          fu_x1,
    output logic [31:0]          fu_x2,
    input  logic [31:0]          fu_y,
    input  logic                 fu_ovf,
    output logic [15:0]          ovf_cnt
);

    localparam int unsigned CNTW = 16;

    logic            s1_v;
    logic            s1_port;
    logic [TAGW-1:0] s1_tag;
    logic            rr;
    logic            adv;
    logic            free;
    logic [1:0]      grant;
    logic            acc;
    logic            acc_port;

    // Advance/free and round-robin grant; req_ready is combinational on req_valid.
    always_comb begin
        adv   = s1_v & (~resp_valid[s1_port] | resp_ready[s1_port]);
        free  = ~s1_v | adv;
        grant = 2'b00;
        if (req_valid[rr]) begin
            grant[rr] = 1'b1;
        end else begin
            grant[~rr] = req_valid[~rr];
        end
        req_ready = free ? grant : 2'b00;
        acc       = |req_ready;
        acc_port  = req_ready[1];
    end

    // Issue stage, arbitration pointer and overflow counter.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_v    <= 1'b0;
            s1_port <= 1'b0;
            s1_tag  <= '0;
            rr      <= 1'b0;
            fu_x1   <= '0;
            fu_x2   <= '0;
            ovf_cnt <= '0;
        end else begin
            if (acc) begin
                fu_x1   <= req_x1[acc_port];
                // Add = sub with x2 negated; sign flip is unconditional (NaN included).
                fu_x2   <= {req_x2[acc_port][31] ^ req_op[acc_port], req_x2[acc_port][30:0]};
                s1_port <= acc_port;
                s1_tag  <= req_tag[acc_port];
                s1_v    <= 1'b1;
                rr      <= ~acc_port;
            end else if (adv) begin
                s1_v <= 1'b0;
            end
            if (adv && fu_ovf && (ovf_cnt != {CNTW{1'b1}})) begin
                ovf_cnt <= ovf_cnt + CNTW'(1);
            end
        end
    end

    // Response buffers: refill wins over drain so a same-cycle swap keeps valid high.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            resp_valid <= '0;
            resp_y     <= '0;
            resp_ovf   <= '0;
            resp_tag   <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (adv && (s1_port == 1'(p))) begin
                    resp_valid[p] <= 1'b1;
                    resp_y[p]     <= fu_y;
                    resp_ovf[p]   <= fu_ovf;
                    resp_tag[p]   <= s1_tag;
                end else if (resp_ready[p]) begin
                    resp_valid[p] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fsub_sched.sv
// Self-checking bench for fsub_sched: directed scenarios plus random traffic,
// checked against a transaction-level model with per-port result queues.
module tb_fsub_sched;

    localparam int unsigned TAGW = 4;

    logic                 clk;
    logic                 rstn;
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [1:0]           req_op;
    logic [1:0][31:0]     req_x1;
    logic [1:0][31:0]     req_x2;
    logic [1:0][TAGW-1:0] req_tag;
    logic [1:0]           resp_valid;
    logic [1:0]           resp_ready;
    logic [1:0][31:0]     resp_y;
    logic [1:0]           resp_ovf;
    logic [1:0][TAGW-1:0] resp_tag;
    logic [31:0]          fu_x1;
    logic [31:0]          fu_x2;
    logic [31:0]          fu_y;
    logic                 fu_ovf;
    logic [15:0]          ovf_cnt;

    fsub_sched #(.TAGW(TAGW)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_x1(req_x1), .req_x2(req_x2), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_y(resp_y),
        .resp_ovf(resp_ovf), .resp_tag(resp_tag),
        .fu_x1(fu_x1), .fu_x2(fu_x2), .fu_y(fu_y), .fu_ovf(fu_ovf),
        .ovf_cnt(ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the external fsub: exact IEEE results for the directed
    // vectors, a deterministic bit mix for arbitrary random operands.
    function automatic logic [32:0] fu_model(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h40400000_3F800000: return {1'b0, 32'h40000000};
            64'h3F800000_C0000000: return {1'b0, 32'h40400000};
            64'h3F800000_3F800000: return {1'b0, 32'h00000000};
            64'h7F7FFFFF_FF7FFFFF: return {1'b1, 32'h7F800000};
            default:               return {a[7] & b[13], a - b};
        endcase
    endfunction

    always_comb {fu_ovf, fu_y} = fu_model(fu_x1, fu_x2);

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: S1 occupancy, buffer occupancy, per-port queues
    // of results in accept order (front = oldest undrained).
    typedef struct packed {
        logic [31:0]     y;
        logic            ovf;
        logic [TAGW-1:0] tag;
    } res_t;

    res_t        q0[$];
    res_t        q1[$];
    logic        m_s1v;
    logic        m_s1p;
    logic        m_s1ovf;
    logic [1:0]  m_rbv;
    logic        m_rr;
    int          m_cnt;
    logic [31:0] m_fx1;
    logic [31:0] m_fx2;

    // Check one cycle just before the rising edge, then advance the model.
    task automatic tick();
        logic       adv;
        logic       fr;
        logic [1:0] g;
        logic [1:0] exp_ready;
        logic [1:0] drain;
        logic [1:0] rbv_n;
        logic       gp;
        logic [31:0] x2e;
        logic [32:0] r;
        res_t       e;
        #1;
        if (!rstn) begin
            q0.delete();
            q1.delete();
            m_s1v = 1'b0; m_s1p = 1'b0; m_s1ovf = 1'b0;
            m_rbv = 2'b00; m_rr = 1'b0; m_cnt = 0;
            m_fx1 = '0; m_fx2 = '0;
        end else begin
            adv = m_s1v && (!m_rbv[m_s1p] || resp_ready[m_s1p]);
            fr  = !m_s1v || adv;
            if (req_valid[m_rr]) g = m_rr ? 2'b10 : 2'b01;
            else                 g = req_valid;
            exp_ready = fr ? g : 2'b00;
            chk("req_ready", 64'(req_ready), 64'(exp_ready));
            chk("resp_valid", 64'(resp_valid), 64'(m_rbv));
            chk("ovf_cnt", 64'(ovf_cnt), 64'(m_cnt));
            chk("fu_x1", 64'(fu_x1), 64'(m_fx1));
            chk("fu_x2", 64'(fu_x2), 64'(m_fx2));
            if (m_rbv[0] && q0.size() != 0) begin
                e = q0[0];
                chk("resp_y0", 64'(resp_y[0]), 64'(e.y));
                chk("resp_ovf0", 64'(resp_ovf[0]), 64'(e.ovf));
                chk("resp_tag0", 64'(resp_tag[0]), 64'(e.tag));
            end
            if (m_rbv[1] && q1.size() != 0) begin
                e = q1[0];
                chk("resp_y1", 64'(resp_y[1]), 64'(e.y));
                chk("resp_ovf1", 64'(resp_ovf[1]), 64'(e.ovf));
                chk("resp_tag1", 64'(resp_tag[1]), 64'(e.tag));
            end
            drain = m_rbv & resp_ready;
            rbv_n = m_rbv & ~drain;
            if (drain[0] && q0.size() != 0) void'(q0.pop_front());
            if (drain[1] && q1.size() != 0) void'(q1.pop_front());
            if (adv) begin
                rbv_n[m_s1p] = 1'b1;
                if (m_s1ovf && m_cnt < 65535) m_cnt++;
            end
            if (exp_ready != 2'b00) begin
                gp  = exp_ready[1];
                x2e = {req_x2[gp][31] ^ req_op[gp], req_x2[gp][30:0]};
                r   = fu_model(req_x1[gp], x2e);
                e   = '{y: r[31:0], ovf: r[32], tag: req_tag[gp]};
                if (gp) q1.push_back(e);
                else    q0.push_back(e);
                m_s1v = 1'b1; m_s1p = gp; m_s1ovf = r[32]; m_rr = ~gp;
                m_fx1 = req_x1[gp]; m_fx2 = x2e;
            end else if (adv) begin
                m_s1v = 1'b0;
            end
            m_rbv = rbv_n;
        end
        @(negedge clk);
    endtask

    task automatic set_req(input int p, input logic op, input logic [31:0] x1,
                           input logic [31:0] x2, input logic [TAGW-1:0] tag);
        req_valid[p] = 1'b1;
        req_op[p]    = op;
        req_x1[p]    = x1;
        req_x2[p]    = x2;
        req_tag[p]   = tag;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        req_valid = 2'b00;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        req_valid = '0; req_op = '0; req_x1 = '0; req_x2 = '0; req_tag = '0;
        resp_ready = 2'b11;
        @(negedge clk);
        do_reset();

        // Reset state
        #1;
        chk("rst_resp_valid", 64'(resp_valid), 64'h0);
        chk("rst_ovf_cnt", 64'(ovf_cnt), 64'h0);
        chk("rst_fu_x1", 64'(fu_x1), 64'h0);
        chk("rst_resp_y0", 64'(resp_y[0]), 64'h0);

        // Port 0 sub: 3.0 - 1.0, result two cycles after accept
        set_req(0, 1'b0, 32'h40400000, 32'h3F800000, 4'h5);
        tick();
        req_valid = 2'b00;
        tick();
        #1;
        chk("sub_valid", 64'(resp_valid[0]), 64'h1);
        chk("sub_y", 64'(resp_y[0]), 64'h40000000);
        chk("sub_ovf", 64'(resp_ovf[0]), 64'h0);
        chk("sub_tag", 64'(resp_tag[0]), 64'h5);
        tick();

        // Port 1 adds: 1.0 + 2.0, 1.0 + (-1.0)
        set_req(1, 1'b1, 32'h3F800000, 32'h40000000, 4'hA);
        tick();
        req_valid = 2'b00;
        tick();
        #1;
        chk("add_y", 64'(resp_y[1]), 64'h40400000);
        chk("add_tag", 64'(resp_tag[1]), 64'hA);
        tick();
        set_req(1, 1'b1, 32'h3F800000, 32'hBF800000, 4'hB);
        tick();
        req_valid = 2'b00;
        tick();
        #1;
        chk("add_zero_y", 64'(resp_y[1]), 64'h0);
        tick();

        // Both ports contending from rr=0: grants alternate, never both
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_req(0, 1'b0, 32'h40400000, 32'h3F800000, 4'(i));
            set_req(1, 1'b1, 32'h3F800000, 32'h40000000, 4'(i + 8));
            #1;
            chk("alt_grant", 64'(req_ready), (i % 2 == 0) ? 64'h1 : 64'h2);
            tick();
        end
        req_valid = 2'b00;
        for (int i = 0; i < 4; i++) tick();

        // Backpressure on port 0: S1 stalls and blocks both ports
        do_reset();
        resp_ready = 2'b10;
        set_req(0, 1'b0, 32'h00000011, 32'h00000001, 4'h1);
        tick();
        set_req(0, 1'b0, 32'h00000022, 32'h00000002, 4'h2);
        tick();
        set_req(0, 1'b0, 32'h00000033, 32'h00000003, 4'h3);
        set_req(1, 1'b0, 32'h00000044, 32'h00000004, 4'h4);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_blocked", 64'(req_ready), 64'h0);
            tick();
        end
        resp_ready = 2'b11;
        tick();
        tick();
        req_valid = 2'b00;
        for (int i = 0; i < 6; i++) tick();
        chk("bp_drained0", 64'(q0.size()), 64'h0);
        chk("bp_drained1", 64'(q1.size()), 64'h0);

        // Overflow: max + max
        do_reset();
        set_req(0, 1'b1, 32'h7F7FFFFF, 32'h7F7FFFFF, 4'h7);
        tick();
        req_valid = 2'b00;
        #1;
        chk("ovf_cnt_before", 64'(ovf_cnt), 64'h0);
        tick();
        #1;
        chk("ovf_flag", 64'(resp_ovf[0]), 64'h1);
        chk("ovf_y", 64'(resp_y[0]), 64'h7F800000);
        chk("ovf_cnt_after", 64'(ovf_cnt), 64'h1);
        tick();

        // Saturation of the overflow counter
        do_reset();
        set_req(0, 1'b1, 32'h7F7FFFFF, 32'h7F7FFFFF, 4'h1);
        for (int i = 0; i < 65540; i++) tick();
        req_valid = 2'b00;
        for (int i = 0; i < 3; i++) tick();
        #1;
        chk("ovf_sat", 64'(ovf_cnt), 64'hFFFF);
        tick();

        // Random traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            for (int p = 0; p < 2; p++) begin
                req_valid[p] = ($urandom_range(0, 3) != 0);
                req_op[p]    = 1'($urandom);
                req_x1[p]    = ($urandom_range(0, 7) == 0) ? 32'h3F800000 : $urandom;
                req_x2[p]    = ($urandom_range(0, 7) == 0) ? 32'h3F800000 : $urandom;
                req_tag[p]   = TAGW'($urandom);
                resp_ready[p] = ($urandom_range(0, 2) != 0);
            end
            tick();
        end
        req_valid = 2'b00;
        resp_ready = 2'b11;
        for (int i = 0; i < 4; i++) tick();

        // Reset with S1 and RB0 occupied
        resp_ready = 2'b00;
        set_req(0, 1'b0, 32'h40400000, 32'h3F800000, 4'hC);
        tick();
        set_req(0, 1'b0, 32'h40400000, 32'h3F800000, 4'hD);
        tick();
        req_valid = 2'b00;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        req_valid = 2'b11;
        #1;
        chk("mid_rst_valid", 64'(resp_valid), 64'h0);
        chk("mid_rst_cnt", 64'(ovf_cnt), 64'h0);
        chk("mid_rst_rr", 64'(req_ready), 64'h1);
        req_valid = 2'b00;
        resp_ready = 2'b11;
        for (int i = 0; i < 5; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
